mul_div_resp_buffer: RTL and testbench

- Decoupling stage between the issue logic and the MUL_DIV execution unit, and between that unit and writeback/commit.
- The MUL_DIV unit drives its response stream without honouring the response ack. This block therefore absorbs every response in a DEPTH-entry FIFO.
- It throttles requests into the unit with a credit counter, so an accepted response can never find the FIFO full.
- The downstream consumer sees a normal req/ack stream and may backpressure freely.

---
 rtl/mul_div_resp_buffer.sv | 116 +++++++++++
 tb/tb_mul_div_resp_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_resp_buffer.sv
// Response buffer between the MUL_DIV unit and writeback: absorbs every response in a FIFO
// and throttles issue with credits so an accepted response always finds a free slot.
module mul_div_resp_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TRX_ID_W = 4,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned DATA_W   = 32,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                up_req_i,
    output logic                up_ack_o,
    output logic                exu_req_o,
    input  logic                exu_ack_i,
    input  logic                exu_resp_req_i,
    output logic                exu_resp_ack_o,
    input  logic [TRX_ID_W-1:0] exu_resp_trx_id_i,
    input  logic                exu_resp_rd0_req_i,
    input  logic [TAG_W-1:0]    exu_resp_rd0_tag_i,
    input  logic [DATA_W-1:0]   exu_resp_rd0_wdata_i,
    output logic                out_req_o,
    input  logic                out_ack_i,
    output logic [TRX_ID_W-1:0] out_trx_id_o,
    output logic                out_rd0_req_o,
    output logic [TAG_W-1:0]    out_rd0_tag_o,
    output logic [DATA_W-1:0]   out_rd0_wdata_o,
    output logic [CNT_W-1:0]    credits_o,
    output logic                ovf_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = TRX_ID_W + 1 + TAG_W + DATA_W;

    logic [CNT_W-1:0] credits_q, credits_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             resp_ack_q;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    out_entry;

    logic credit_ok, req_fire;
    logic empty, full;
    logic push, push_en, pop;

    assign credit_ok = (credits_q != '0);
    assign exu_req_o = up_req_i && credit_ok;
    assign up_ack_o  = exu_ack_i && credit_ok;
    assign req_fire  = up_req_i && exu_ack_i && credit_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Ack is registered so a response in the cycle reset releases is not captured.
    assign exu_resp_ack_o = resp_ack_q;
    assign push           = exu_resp_req_i && resp_ack_q;
    assign push_en        = push && !full;
    assign pop            = out_req_o && out_ack_i;

    assign wr_entry = {exu_resp_trx_id_i, exu_resp_rd0_req_i, exu_resp_rd0_tag_i,
                       exu_resp_rd0_wdata_i};

    always_comb begin
        credits_d = credits_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        if (req_fire && !pop) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (pop && !req_fire) begin
            credits_d = credits_q + CNT_W'(1);
        end
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
        if (push && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q  <= CNT_W'(DEPTH);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            resp_ack_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            resp_ack_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Head fields read as zero while empty so reset and idle outputs are defined.
    assign out_entry = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign {out_trx_id_o, out_rd0_req_o, out_rd0_tag_o, out_rd0_wdata_o} = out_entry;

    assign out_req_o = !empty;
    assign credits_o = credits_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_mul_div_resp_buffer.sv
// Directed bench for mul_div_resp_buffer: reset, single op, backpressure, concurrent
// push/pop, wrap-around streaming, forced overflow and asynchronous reset.
module tb_mul_div_resp_buffer;

    logic        clk;
    logic        rst;
    logic        up_req, up_ack, exu_req, exu_ack;
    logic        resp_req, resp_ack, resp_rd0_req;
    logic [3:0]  resp_trx;
    logic [4:0]  resp_tag;
    logic [31:0] resp_wdata;
    logic        out_req, out_ack, out_rd0_req;
    logic [3:0]  out_trx;
    logic [4:0]  out_tag;
    logic [31:0] out_wdata;
    logic [2:0]  credits;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_resp_buffer #(
        .DEPTH    (4),
        .TRX_ID_W (4),
        .TAG_W    (5),
        .DATA_W   (32)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .up_req_i             (up_req),
        .up_ack_o             (up_ack),
        .exu_req_o            (exu_req),
        .exu_ack_i            (exu_ack),
        .exu_resp_req_i       (resp_req),
        .exu_resp_ack_o       (resp_ack),
        .exu_resp_trx_id_i    (resp_trx),
        .exu_resp_rd0_req_i   (resp_rd0_req),
        .exu_resp_rd0_tag_i   (resp_tag),
        .exu_resp_rd0_wdata_i (resp_wdata),
        .out_req_o            (out_req),
        .out_ack_i            (out_ack),
        .out_trx_id_o         (out_trx),
        .out_rd0_req_o        (out_rd0_req),
        .out_rd0_tag_o        (out_tag),
        .out_rd0_wdata_o      (out_wdata),
        .credits_o            (credits),
        .ovf_err_o            (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_resp(input logic v, input logic [3:0] trx, input logic [4:0] tag,
                              input logic [31:0] d);
        resp_req     = v;
        resp_rd0_req = v;
        resp_trx     = trx;
        resp_tag     = tag;
        resp_wdata   = d;
    endtask

    int issued, sent, recv, mcred, mocc;
    int due [10];
    logic fire, push, pop;

    initial begin
        rst     = 1'b1;
        up_req  = 1'b0;
        exu_ack = 1'b0;
        out_ack = 1'b0;
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);

        // Reset state
        #3;
        check_eq("rst_resp_ack", resp_ack, 0);
        check_eq("rst_out_req", out_req, 0);
        check_eq("rst_credits", credits, 4);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_out_wdata", out_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        check_eq("idle_resp_ack", resp_ack, 1);
        exu_ack = 1'b1;
        #1 check_eq("idle_up_ack_hi", up_ack, 1);
        exu_ack = 1'b0;
        #1 check_eq("idle_up_ack_lo", up_ack, 0);
        check_eq("idle_exu_req", exu_req, 0);

        // Single operation
        up_req  = 1'b1;
        exu_ack = 1'b1;
        #1;
        check_eq("single_exu_req", exu_req, 1);
        check_eq("single_up_ack", up_ack, 1);
        tick();
        up_req  = 1'b0;
        exu_ack = 1'b0;
        check_eq("single_credits3", credits, 3);
        drive_resp(1'b1, 4'd2, 5'd5, 32'h0000_0006);
        #1 check_eq("single_no_bypass", out_req, 0);
        tick();
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
        check_eq("single_out_req", out_req, 1);
        check_eq("single_trx", out_trx, 2);
        check_eq("single_tag", out_tag, 5);
        check_eq("single_wdata", out_wdata, 32'h6);
        check_eq("single_rd0", out_rd0_req, 1);
        tick();
        check_eq("single_hold_req", out_req, 1);
        check_eq("single_hold_trx", out_trx, 2);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check_eq("single_popped", out_req, 0);
        check_eq("single_credits4", credits, 4);

        // Backpressure: four requests, responses two cycles later, nothing drained
        up_req  = 1'b1;
        exu_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) drive_resp(1'b1, 4'(c - 2), 5'(c), 32'(100 + c - 2));
            else        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
            if (c == 4) begin
                #1;
                check_eq("bp_up_ack_blocked", up_ack, 0);
                check_eq("bp_exu_req_blocked", exu_req, 0);
            end
            tick();
        end
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
        up_req = 1'b0;
        check_eq("bp_credits0", credits, 0);
        check_eq("bp_out_req", out_req, 1);
        check_eq("bp_head0", out_trx, 0);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check_eq("bp_credits1", credits, 1);
        check_eq("bp_head1", out_trx, 1);
        up_req = 1'b1;
        #1 check_eq("bp_up_ack_again", up_ack, 1);
        tick();
        up_req = 1'b0;
        check_eq("bp_credits0_again", credits, 0);
        out_ack = 1'b1;
        tick();
        check_eq("bp_credits_pop1", credits, 1);
        check_eq("bp_head2", out_trx, 2);

        // Push, pop and request fire together at occupancy 2
        up_req = 1'b1;
        drive_resp(1'b1, 4'd4, 5'd6, 32'd104);
        #1 check_eq("sim_up_ack", up_ack, 1);
        tick();
        up_req = 1'b0;
        check_eq("sim_credits", credits, 1);
        check_eq("sim_head3", out_trx, 3);
        check_eq("sim_wdata3", out_wdata, 103);
        drive_resp(1'b1, 4'd5, 5'd7, 32'd105);
        tick();
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
        check_eq("sim_credits2", credits, 2);
        check_eq("sim_head4", out_trx, 4);
        check_eq("sim_wdata4", out_wdata, 104);
        tick();
        check_eq("sim_credits3", credits, 3);
        check_eq("sim_head5", out_trx, 5);
        check_eq("sim_wdata5", out_wdata, 105);
        tick();
        check_eq("sim_credits4", credits, 4);
        check_eq("sim_empty", out_req, 0);
        out_ack = 1'b0;

        // Wrap-around stream of 10 ops with random drain
        issued = 0;
        sent   = 0;
        recv   = 0;
        mcred  = 4;
        mocc   = 0;
        exu_ack = 1'b1;
        for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            up_req = (issued < 10);
            if (sent < issued && due[sent] == cyc)
                drive_resp(1'b1, 4'(sent), 5'(sent), 32'(sent * 3));
            else
                drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
            out_ack = 1'($urandom_range(0, 1));
            #1;
            fire = up_req && (mcred != 0);
            push = resp_req;
            pop  = out_ack && (mocc != 0);
            check_eq("wrap_up_ack", up_ack, 32'(mcred != 0));
            check_eq("wrap_out_req", out_req, 32'(mocc != 0));
            if (pop) begin
                check_eq("wrap_trx", out_trx, 32'(recv));
                check_eq("wrap_wdata", out_wdata, 32'(recv * 3));
                recv++;
            end
            tick();
            if (fire) begin
                due[issued] = cyc + 2;
                issued++;
            end
            if (push) sent++;
            mcred = mcred - int'(fire) + int'(pop);
            mocc  = mocc + int'(push) - int'(pop);
            check_eq("wrap_credits", credits, 32'(mcred));
        end
        up_req  = 1'b0;
        out_ack = 1'b0;
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
        check_eq("wrap_recv_all", 32'(recv), 10);
        check_eq("wrap_ovf", ovf, 0);
        check_eq("wrap_credits_end", credits, 4);

        // Forced overflow
        up_req = 1'b1;
        repeat (4) tick();
        up_req = 1'b0;
        check_eq("ovf_credits0", credits, 0);
        for (int i = 0; i < 4; i++) begin
            drive_resp(1'b1, 4'(10 + i), 5'(i), 32'(200 + i));
            tick();
        end
        drive_resp(1'b1, 4'd15, 5'd0, 32'd999);
        #1 check_eq("ovf_before", ovf, 0);
        tick();
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
        check_eq("ovf_set", ovf, 1);
        check_eq("ovf_head_kept", out_trx, 10);
        check_eq("ovf_head_wdata", out_wdata, 200);
        tick();
        check_eq("ovf_sticky", ovf, 1);
        out_ack = 1'b1;
        tick();
        check_eq("ovf_head11", out_trx, 11);
        up_req = 1'b1;
        tick();
        check_eq("ovf_head12", out_trx, 12);
        check_eq("ovf_still_set", ovf, 1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_out_req", out_req, 0);
        check_eq("arst_credits", credits, 4);
        check_eq("arst_ovf", ovf, 0);
        check_eq("arst_resp_ack", resp_ack, 0);
        check_eq("arst_out_trx", out_trx, 0);
        up_req  = 1'b0;
        out_ack = 1'b0;
        drive_resp(1'b1, 4'd7, 5'd1, 32'd77);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        drive_resp(1'b0, 4'd0, 5'd0, 32'd0);
        check_eq("rel_resp_dropped", out_req, 0);
        check_eq("rel_credits", credits, 4);
        check_eq("rel_resp_ack", resp_ack, 1);
        tick();
        check_eq("rel_still_empty", out_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
